// File: rtl/pad_test_core.sv
// Core-side pad test logic: input synchroniser, debounced mode select, registered test patterns.
// Optional edge-count mode 11 is enabled by defining PAD_TEST_EDGE_CNT_EN.
module pad_test_core #(
    parameter int unsigned N_IN        = 10,
    parameter int unsigned N_OUT       = 10,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MODE_STABLE = 4,
    parameter int unsigned DIV_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  ui_in,
    output logic [N_OUT-1:0] uo_out,
    output logic [1:0]       mode_o,
    output logic             tick_o
);

    typedef enum logic [1:0] {
        ModeLoop  = 2'b00,
        ModeWalk  = 2'b01,
        ModeCount = 2'b10,
        ModeEdge  = 2'b11
    } mode_e;

    localparam int unsigned EXT_W = (N_IN > N_OUT) ? N_IN : N_OUT;
    localparam logic [2:0] STAB_MAX = 3'(MODE_STABLE - 1);

    logic [N_IN-1:0]  sync_q [SYNC_STAGES];
    logic [N_IN-1:0]  ui_s;
    logic [1:0]       cand_q;
    logic [2:0]       stab_q, stab_d;
    mode_e            mode_q, mode_d;
    logic             restart;
    logic [DIV_W-1:0] presc_q;
    logic             tick, tick_q;
    logic [N_OUT-1:0] pat_q, pat_d;
    logic [EXT_W-1:0] ui_ext;
    logic [N_OUT-1:0] loop_val;

    assign ui_s     = sync_q[SYNC_STAGES-1];
    assign ui_ext   = EXT_W'(ui_s);
    assign loop_val = ui_ext[N_OUT-1:0];
    assign tick     = &presc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= ui_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Mode filter: candidate must hold for MODE_STABLE cycles before it is accepted.
    always_comb begin
        stab_d  = stab_q;
        mode_d  = mode_q;
        restart = 1'b0;
        if (ui_s[9:8] != cand_q) begin
            stab_d = '0;
        end else if (stab_q < STAB_MAX) begin
            stab_d = stab_q + 3'd1;
        end else if (cand_q != mode_q) begin
            mode_d  = mode_e'(cand_q);
            restart = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q  <= '0;
            stab_q  <= '0;
            mode_q  <= ModeLoop;
            presc_q <= '0;
            tick_q  <= 1'b0;
            pat_q   <= '0;
        end else begin
            cand_q  <= ui_s[9:8];
            stab_q  <= stab_d;
            mode_q  <= mode_d;
            presc_q <= restart ? '0 : presc_q + 1'b1;
            tick_q  <= tick;
            pat_q   <= pat_d;
        end
    end

`ifdef PAD_TEST_EDGE_CNT_EN
    logic edge_prev_q;
    logic rise;

    assign rise = ui_s[0] & ~edge_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_prev_q <= 1'b0;
        else        edge_prev_q <= ui_s[0];
    end
`endif

    // Restart takes priority over a coincident tick.
    always_comb begin
        pat_d = pat_q;
        if (restart) begin
            unique case (mode_d)
                ModeLoop:  pat_d = loop_val;
                ModeWalk:  pat_d = N_OUT'(1);
                ModeCount: pat_d = '0;
                ModeEdge:  pat_d = '0;
            endcase
        end else begin
            unique case (mode_q)
                ModeLoop: pat_d = loop_val;
                ModeWalk: begin
                    if (tick) pat_d = {pat_q[N_OUT-2:0], pat_q[N_OUT-1]};
                end
                ModeCount: begin
                    if (tick) pat_d = pat_q + 1'b1;
                end
                ModeEdge: begin
`ifdef PAD_TEST_EDGE_CNT_EN
                    if (rise && !(&pat_q)) pat_d = pat_q + 1'b1;
`else
                    pat_d = '0;
`endif
                end
            endcase
        end
    end

    assign uo_out = pat_q;
    assign mode_o = mode_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_pad_test_core.sv
// Self-checking bench for pad_test_core (DIV_W=4): scoreboard queue of expected pad outputs.
module tb_pad_test_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] ui_in = '0;
    logic [9:0] uo_out;
    logic [1:0] mode_o;
    logic       tick_o;

    int total = 0;
    int bad = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_v;

    pad_test_core #(
        .N_IN(10), .N_OUT(10), .SYNC_STAGES(2), .MODE_STABLE(4), .DIV_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ui_in(ui_in),
        .uo_out(uo_out),
        .mode_o(mode_o),
        .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_mode(input logic [1:0] m, input string name);
        int n = 0;
        while (mode_o !== m && n < 12) begin
            cyc(1);
            n++;
        end
        total++;
        if (mode_o !== m) begin
            bad++;
            $display("FAIL %s: mode_o=%0d required %0d within 12 cycles", name, mode_o, m);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ui_in = 10'h3FF;
        cyc(3);
        total++;
        if (uo_out !== 10'h000) begin
            bad++; $display("FAIL reset_uo: got %h want 000", uo_out);
        end
        total++;
        if (mode_o !== 2'd0) begin
            bad++; $display("FAIL reset_mode: got %0d want 0", mode_o);
        end
        total++;
        if (tick_o !== 1'b0) begin
            bad++; $display("FAIL reset_tick: got %b want 0", tick_o);
        end
        rst_n = 1'b1;
        ui_in = 10'h0AA;
        exp_q.push_back(10'h0AA);
        cyc(2);
        total++;
        if (uo_out !== 10'h000) begin
            bad++; $display("FAIL loop_early: got %h want 000", uo_out);
        end
        cyc(1);
        exp_v = exp_q.pop_front();
        total++;
        if (uo_out !== exp_v) begin
            bad++; $display("FAIL loop_latency: got %h want %h", uo_out, exp_v);
        end
        total++;
        if (mode_o !== 2'd0) begin
            bad++; $display("FAIL loop_mode: got %0d want 0", mode_o);
        end
    endtask

    task automatic test_walk;
        ui_in = 10'h100;
        wait_mode(2'd1, "walk_enter");
        total++;
        if (uo_out !== 10'h001) begin
            bad++; $display("FAIL walk_load: got %h want 001", uo_out);
        end
        for (int i = 1; i <= 10; i++) exp_q.push_back(10'(1 << (i % 10)));
        for (int i = 0; i < 10; i++) begin
            int n = 0;
            do begin
                cyc(1);
                n++;
            end while (!tick_o && n < 20);
            total++;
            if (n != 16) begin
                bad++; $display("FAIL walk_period: got %0d cycles want 16", n);
            end
            exp_v = exp_q.pop_front();
            total++;
            if (uo_out !== exp_v) begin
                bad++; $display("FAIL walk_step%0d: got %h want %h", i, uo_out, exp_v);
            end
        end
    endtask

    task automatic test_count;
        ui_in = 10'h200;
        wait_mode(2'd2, "count_enter");
        total++;
        if (uo_out !== 10'h000) begin
            bad++; $display("FAIL count_load: got %h want 000", uo_out);
        end
        for (int i = 1; i <= 1024; i++) begin
            int n = 0;
            exp_q.push_back(10'(i));
            do begin
                cyc(1);
                n++;
            end while (!tick_o && n < 20);
            exp_v = exp_q.pop_front();
            total++;
            if (!tick_o || uo_out !== exp_v) begin
                bad++;
                $display("FAIL count_step%0d: got %h tick=%b want %h", i, uo_out, tick_o, exp_v);
            end
        end
    endtask

    task automatic test_glitch;
        bit stayed = 1'b1;
        ui_in = 10'h000;
        wait_mode(2'd0, "loop_reenter");
        ui_in = 10'h155;
        cyc(3);
        ui_in = 10'h055;
        exp_q.push_back(10'h055);
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (mode_o !== 2'd0) stayed = 1'b0;
        end
        total++;
        if (!stayed) begin
            bad++; $display("FAIL glitch_mode: mode_o left 0, now %0d", mode_o);
        end
        exp_v = exp_q.pop_front();
        total++;
        if (uo_out !== exp_v) begin
            bad++; $display("FAIL glitch_loop: got %h want %h", uo_out, exp_v);
        end
    endtask

    task automatic test_edge;
        ui_in = 10'h300;
        wait_mode(2'd3, "edge_enter");
        total++;
        if (uo_out !== 10'h000) begin
            bad++; $display("FAIL edge_load: got %h want 000", uo_out);
        end
        for (int p = 1; p <= 5; p++) begin
`ifdef PAD_TEST_EDGE_CNT_EN
            exp_q.push_back(10'(p));
`else
            exp_q.push_back(10'h000);
`endif
            ui_in = 10'h301;
            cyc(2);
            ui_in = 10'h300;
            cyc(2);
            exp_v = exp_q.pop_front();
            total++;
            if (uo_out !== exp_v) begin
                bad++; $display("FAIL edge_pulse%0d: got %h want %h", p, uo_out, exp_v);
            end
        end
    endtask

    task automatic test_async_reset;
        ui_in = 10'h100;
        wait_mode(2'd1, "walk_reenter");
        cyc(17);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (uo_out !== 10'h000 || mode_o !== 2'd0 || tick_o !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: uo=%h mode=%0d tick=%b want 000/0/0", uo_out, mode_o, tick_o);
        end
        ui_in = 10'h0F3;
        cyc(2);
        rst_n = 1'b1;
        exp_q.push_back(10'h0F3);
        cyc(3);
        exp_v = exp_q.pop_front();
        total++;
        if (uo_out !== exp_v || mode_o !== 2'd0) begin
            bad++;
            $display("FAIL post_reset_loop: uo=%h mode=%0d want %h/0", uo_out, mode_o, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_count();
        test_glitch();
        test_edge();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
